// File: rtl/line_burst_pkg.sv
// Shared constants and state encoding for the cache-line <-> memory-burst adaptor.
package line_burst_pkg;
  localparam int LINE_W  = 256;
  localparam int BURST_W = 64;
  localparam int BEATS   = LINE_W / BURST_W;
  localparam int BEAT_IW = $clog2(BEATS);
  localparam int OFFS_W  = 5;
  localparam logic [31:0] LINE_OFFS_MASK = 32'h0000_001F;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;
endpackage

// File: rtl/line_burst_adaptor.sv
// Converts one cache-line transfer into a 4-beat memory burst (fill or writeback).
// Define LINE_BURST_TIMEOUT_EN to build the beat watchdog and sticky err_o.
module line_burst_adaptor #(
  parameter int LINE_W  = line_burst_pkg::LINE_W,
  parameter int BURST_W = line_burst_pkg::BURST_W
`ifdef LINE_BURST_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i,
  output logic               err_o
);
  import line_burst_pkg::*;

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int CNT_W  = $clog2(NBEATS);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                last_beat;
  logic                tmo_abort;

  assign cnt_inc   = cnt_q + 1'b1;
  assign last_beat = (cnt_q == CNT_W'(NBEATS - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    line_d  = line_q;
    burst_d = burst_q;
    case (state_q)
      S_IDLE: begin
        // writeback wins over fill when both are requested
        if (write_i) begin
          wline_d = line_i;
          addr_d  = address_i;
          burst_d = line_i[BURST_W-1:0];
          cnt_d   = '0;
          state_d = S_WRITE;
        end else if (read_i) begin
          addr_d  = address_i;
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (resp_i) begin
          line_d[int'(cnt_q)*BURST_W +: BURST_W] = burst_i;
          cnt_d = cnt_inc;
          if (last_beat) state_d = S_DONE;
        end
      end
      S_WRITE: begin
        if (resp_i) begin
          cnt_d   = cnt_inc;
          burst_d = wline_q[int'(cnt_inc)*BURST_W +: BURST_W];
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (tmo_abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      line_q  <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      line_q  <= line_d;
      burst_q <= burst_d;
    end
  end

`ifdef LINE_BURST_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             err_q, err_d;

  // Counter is zero outside a burst, so it restarts on every entry to READ/WRITE.
  always_comb begin
    tmo_d     = '0;
    err_d     = err_q;
    tmo_abort = 1'b0;
    if ((state_q == S_READ || state_q == S_WRITE) && !resp_i) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
        tmo_abort = 1'b1;
        err_d     = 1'b1;
        tmo_d     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign tmo_abort = 1'b0;
  assign err_o     = 1'b0;
`endif

  assign read_o    = (state_q == S_READ);
  assign write_o   = (state_q == S_WRITE);
  assign resp_o    = (state_q == S_DONE);
  assign address_o = addr_q & ~LINE_OFFS_MASK;
  assign line_o    = line_q;
  assign burst_o   = burst_q;
endmodule

// File: tb/tb_line_burst_adaptor.sv
// Self-checking bench: directed table, random transfers vs. a line-level model, reset/hold corners.
module tb_line_burst_adaptor;
  import line_burst_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LINE_W-1:0]  line_i, line_o;
  logic [31:0]        address_i, address_o;
  logic               read_i, write_i, resp_o;
  logic [BURST_W-1:0] burst_i, burst_o;
  logic               read_o, write_o, resp_i, err_o;

  always #5 clk = ~clk;

  line_burst_adaptor dut (
    .clk(clk), .rst_n(rst_n), .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i), .err_o(err_o)
  );

  int nvec = 0;
  int nerr = 0;
  logic [255:0] model_line;

  typedef struct {
    bit           wr;
    bit           both;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [15:0]  pat;
    logic [31:0]  exp_addr;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk_all_zero(input string nm);
    chk({nm, ".line_o"},    line_o,    '0);
    chk({nm, ".burst_o"},   burst_o,   '0);
    chk({nm, ".address_o"}, address_o, '0);
    chk({nm, ".read_o"},    read_o,    '0);
    chk({nm, ".write_o"},   write_o,   '0);
    chk({nm, ".resp_o"},    resp_o,    '0);
    chk({nm, ".err_o"},     err_o,     '0);
  endtask

  // Called at a negedge with the DUT idle. pat bit n = resp_i in the n-th burst cycle.
  task automatic xfer(input bit wr, input bit both, input logic [31:0] addr,
                      input logic [255:0] data, input logic [15:0] pat,
                      input logic [31:0] exp_addr, input bit keep, input bit scramble);
    int beat = 0;
    int step = 0;
    address_i = addr;
    line_i    = wr ? data : rnd256();
    read_i    = !wr || both;
    write_i   = wr;
    resp_i    = 1'b0;
    burst_i   = '0;
    while (beat < 4 && step < 64) begin
      @(negedge clk);
      chk("strobe.read_o",  read_o,  !wr);
      chk("strobe.write_o", write_o, wr);
      chk("burst.resp_o",   resp_o,  1'b0);
      if (step == 0) chk("address_o", address_o, exp_addr);
      if (wr) chk($sformatf("burst_o.beat%0d", beat), burst_o, data[64*beat +: 64]);
      if (scramble && step > 0) begin
        line_i    = rnd256();
        address_i = $urandom;
        if (!wr) write_i = 1'($urandom_range(0, 1));
      end
      resp_i  = pat[step % 16];
      burst_i = resp_i ? data[64*beat +: 64] : rnd256()[63:0];
      if (resp_i) beat++;
      step++;
    end
    if (beat < 4) chk("beat_budget", 32'(beat), 32'd4);
    @(negedge clk);
    chk("done.resp_o",    resp_o,    1'b1);
    chk("done.read_o",    read_o,    1'b0);
    chk("done.write_o",   write_o,   1'b0);
    chk("done.err_o",     err_o,     1'b0);
    chk("done.address_o", address_o, exp_addr);
    if (!wr) model_line = data;
    chk("done.line_o",    line_o,    model_line);
    resp_i  = 1'($urandom_range(0, 1));
    burst_i = rnd256()[63:0];
    if (!keep) begin
      read_i  = 1'b0;
      write_i = 1'b0;
    end
    @(negedge clk);
    chk("idle.resp_o",  resp_o,  1'b0);
    chk("idle.read_o",  read_o,  1'b0);
    chk("idle.write_o", write_o, 1'b0);
    resp_i = 1'b0;
    if (!keep) begin
      resp_i  = 1'b1;
      burst_i = rnd256()[63:0];
      @(negedge clk);
      chk("idle_resp.line_o", line_o, model_line);
      chk("idle_resp.read_o", read_o, 1'b0);
      resp_i = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [255:0] d;
    rst_n = 1'b0; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    resp_i = 1'b0; burst_i = '0; model_line = '0;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;

    vecs.push_back('{1'b0, 1'b0, 32'h0000_1234,
                     {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}}, 16'hFFFF, 32'h0000_1220});
    vecs.push_back('{1'b1, 1'b0, 32'h8000_00FF,
                     {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}}, 16'h0035, 32'h8000_00E0});
    vecs.push_back('{1'b1, 1'b1, 32'hDEAD_BEEF,
                     {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                      64'h5555_AAAA_5555_AAAA, 64'h0F0F_F0F0_0F0F_F0F0}, 16'hFFFF, 32'hDEAD_BEE0});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF,
                     {64'hCAFE_0003_CAFE_0003, 64'hCAFE_0002_CAFE_0002,
                      64'hCAFE_0001_CAFE_0001, 64'hCAFE_0000_CAFE_0000}, 16'h9249, 32'hFFFF_FFE0});
    vecs.push_back('{1'b1, 1'b0, 32'h0000_0040,
                     {64'h1, 64'h2, 64'h3, 64'h4}, 16'hFFFF, 32'h0000_0040});

    for (int i = 0; i < vecs.size(); i++)
      xfer(vecs[i].wr, vecs[i].both, vecs[i].addr, vecs[i].data, vecs[i].pat,
           vecs[i].exp_addr, 1'b0, 1'b0);

    // Random transfers: model is the line/address arithmetic, checked beat by beat.
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      logic [15:0] p;
      a = $urandom;
      p = 16'($urandom);
      if ($countones(p) < 4) p = p | 16'h8421;
      xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, rnd256(), p,
           a - (a % 32), 1'b0, 1'b1);
    end

    // Reset after beat 1 of a fill: everything clears, next fill is a clean 4 beats.
    d = rnd256();
    read_i = 1'b1; address_i = 32'h0000_5678;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      resp_i = 1'b1; burst_i = d[64*b +: 64];
    end
    @(negedge clk);
    rst_n = 1'b0; read_i = 1'b0; resp_i = 1'b0;
    @(negedge clk);
    chk_all_zero("midreset");
    model_line = '0;
    rst_n = 1'b1;
    d = rnd256();
    xfer(1'b0, 1'b0, 32'h0000_5678, d, 16'hFFFF, 32'h0000_5660, 1'b0, 1'b0);

    // Request held one cycle past resp_o starts a second transfer.
    d = rnd256();
    xfer(1'b0, 1'b0, 32'h0001_0010, d, 16'hFFFF, 32'h0001_0000, 1'b1, 1'b0);
    d = rnd256();
    xfer(1'b0, 1'b0, 32'h0001_0010, d, 16'h00F3, 32'h0001_0000, 1'b0, 1'b0);
    xfer(1'b1, 1'b0, 32'h0002_003F, rnd256(), 16'hFFFF, 32'h0002_0020, 1'b1, 1'b0);
    xfer(1'b1, 1'b0, 32'h0002_003F, rnd256(), 16'h0F0F, 32'h0002_0020, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/line_burst_adaptor.md
Name: line_burst_adaptor

Overview:
- Sits directly downstream of the cache datapath: converts one 256-bit cache-line transfer into a 4-beat, 64-bit burst on the physical-memory port, in both directions.
- Cache side sees one request / one response per line. Memory side sees a held read/write strobe plus one resp per beat.
- Used for line fills (read) and dirty-line writebacks (write).

Parameters:
- LINE_W, 256, cache-line width in bits.
- BURST_W, 64, memory beat width in bits. BEATS = LINE_W/BURST_W = 4.
- TIMEOUT_CYCLES, 1024, watchdog limit. Used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- line_i  in  LINE_W  writeback line from cache.
- line_o  out  LINE_W  assembled fill line to cache.
- address_i  in  32  cache request address.
- read_i  in  1  cache line-read request, level.
- write_i  in  1  cache line-write request, level.
- resp_o  out  1  one-cycle completion pulse to cache.
- burst_i  in  BURST_W  memory read beat.
- burst_o  out  BURST_W  memory write beat.
- address_o  out  32  line-aligned memory address.
- read_o  out  1  memory read strobe.
- write_o  out  1  memory write strobe.
- resp_i  in  1  memory beat-valid/accepted, one per beat.
- err_o  out  1  sticky timeout error (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low at a clock edge, any state, including mid-burst):
  - State goes to IDLE; beat counter = 0.
  - line_o, burst_o, address_o = 0; read_o, write_o, resp_o, err_o = 0.
  - No partial completion is reported.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - Sample requests each cycle.
  - write_i high -> latch line_i and address_i, go to WRITE. write_i has priority when read_i and write_i are both high.
  - Otherwise, read_i high -> latch address_i, go to READ.
- address_o = {latched address[31:5], 5'b0}. Held for the whole burst.
- READ:
  - read_o = 1, from the first cycle in READ through the cycle resp_i arrives for beat 3.
  - On each cycle with resp_i = 1: line_o[64*k +: 64] <= burst_i, where k = beat counter; then k increments.
  - Beat order is ascending: beat 0 carries bits [63:0].
  - Gaps (resp_i = 0 between beats) are legal; read_o stays high and the counter holds.
  - After beat 3: go to DONE.
- WRITE:
  - write_o = 1.
  - burst_o = latched_line[64*k +: 64], registered so it is valid in the same cycle write_o is asserted.
  - resp_i = 1 means beat k accepted: advance k and present the next beat on the following cycle.
  - After beat 3: go to DONE.
- DONE:
  - resp_o = 1 for exactly one cycle; read_o = write_o = 0; then go to IDLE.
  - line_o stays stable after a read until the next read's beat 0 overwrites it.
  - Latency with back-to-back beats: request seen in IDLE at cycle T -> strobe at T+1 -> beats at T+1..T+4 -> resp_o at T+5.
- Cache contract: hold read_i/write_i and line_i/address_i until resp_o is seen. A request still high in IDLE the cycle after resp_o is treated as a new request.
- Changes to read_i, write_i or line_i during READ/WRITE are ignored.
- resp_i while IDLE or DONE is ignored and does not advance the counter.
- Beat counter is 2 bits and wraps to 0 on entering DONE.

Optional Feature:
- Macro: LINE_BURST_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to READ/WRITE and on every resp_i. It increments each cycle in READ/WRITE while resp_i = 0.
  - Reaching TIMEOUT_CYCLES aborts to IDLE: strobes drop, err_o = 1 sticky, no resp_o.
  - err_o clears only on reset.
- Undefined: no counter logic is built; err_o is tied 0; bursts wait indefinitely.

Decomposition:
- Package line_burst_pkg:
  - state enum (IDLE, READ, WRITE, DONE);
  - LINE_W, BURST_W, BEATS and beat-index width constants;
  - the line-offset mask constant (5 bits).
- Single module. No sub-module is needed; beat slicing is an indexed part-select on the counter.

Test Plan:
1. Read, back-to-back beats: address_i = 0x0000_1234, read_i = 1; resp_i on 4 consecutive cycles with burst_i = 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o = 0x0000_1220; line_o = {0x44..,0x33..,0x22..,0x11..}; resp_o high exactly one cycle, 5 cycles after the request is sampled.
2. Write with gaps: line_i = {0xD..,0xC..,0xB..,0xA..}, write_i = 1; resp_i toggles 1,0,1,0,1,1 -> burst_o shows 0xA..,0xB..,0xC..,0xD.. in order; write_o held until the 4th resp_i; single resp_o.
3. Simultaneous read_i = write_i = 1 in IDLE -> WRITE path taken: write_o = 1, read_o = 0.
4. Reset asserted after beat 1 of a read -> next cycle all outputs 0 and state IDLE; a following read completes normally with a full 4 beats.
5. Request held one cycle past resp_o -> second transfer starts; resp_i while IDLE does not change line_o.
6. With LINE_BURST_TIMEOUT_EN and TIMEOUT_CYCLES = 16: read with no resp_i -> read_o drops after 16 cycles, err_o = 1 sticky, resp_o never asserted.
